// File: rtl/draw_commit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : draw_commit_scheduler
// Brief    : Turns accepted draw requests into one object-storage write each,
//            using an external sqrt unit for circles and a 4-cycle min/max fold
//            for rectangles; also services slot deletes. Optional macro
//            DRAW_COMMIT_VEL_INIT_EN adds initial-velocity inputs.
// Revision : 1.0
// ============================================================================
module draw_commit_scheduler #(
    parameter int NUM_SLOTS    = 8,
    parameter int SLOT_W       = 3,
    parameter int SQRT_TIMEOUT = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 draw_valid_in,
    output logic                 draw_ready_out,
    input  logic [82:0]          draw_props_in,
`ifdef DRAW_COMMIT_VEL_INIT_EN
    input  logic [15:0]          init_vel_x_in,
    input  logic [15:0]          init_vel_y_in,
`endif
    input  logic                 del_valid_in,
    input  logic [SLOT_W-1:0]    del_slot_in,
    output logic                 del_ready_out,
    output logic                 sqrt_start_out,
    output logic [19:0]          sqrt_operand_out,
    input  logic                 sqrt_done_in,
    input  logic [9:0]           sqrt_result_in,
    output logic                 wr_en_out,
    output logic [SLOT_W-1:0]    wr_addr_out,
    output logic [90:0]          wr_data_out,
    output logic [NUM_SLOTS-1:0] occupancy_out,
    output logic                 full_out,
    output logic                 busy_out,
    output logic                 err_out
);

    localparam int         C_CNT_W     = $clog2(SQRT_TIMEOUT + 1);
    localparam logic [1:0] C_ID_CIRCLE = 2'b01;
    localparam logic [1:0] C_ID_LINE   = 2'b10;
    localparam logic [1:0] C_ID_RECT   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_SQRT_WAIT = 3'd2,
        S_MINMAX    = 3'd3,
        S_WRITE     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [82:0]            props_q, props_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [9:0]             cx_q, cx_d, cy_q, cy_d;
    logic [9:0]             min_x_q, min_x_d, max_x_q, max_x_d;
    logic [9:0]             min_y_q, min_y_d, max_y_q, max_y_d;
    logic [1:0]             step_q, step_d;
    logic [C_CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [NUM_SLOTS-1:0]   occ_q, occ_d;
    logic                   err_q, err_d, busy_q, busy_d, full_q, full_d;
    logic                   sqrt_start_q, sqrt_start_d;
    logic [19:0]            sqrt_operand_q, sqrt_operand_d;
    logic                   wr_en_q, wr_en_d;
    logic [SLOT_W-1:0]      wr_addr_q, wr_addr_d;
    logic [90:0]            wr_data_q, wr_data_d;
`ifdef DRAW_COMMIT_VEL_INIT_EN
    logic [15:0]            vel_x_q, vel_x_d, vel_y_q, vel_y_d;
`endif

    logic [SLOT_W-1:0]      w_free_slot;
    logic [10:0]            w_sum_x, w_sum_y;
    logic [9:0]             w_cx, w_cy, w_dx, w_dy;
    logic [19:0]            w_sq_x, w_sq_y;
    logic [9:0]             w_pt_x, w_pt_y;
    logic                   w_enter_write;
    logic [35:0]            w_params;
    logic [9:0]             w_pos_x, w_pos_y;
    logic [15:0]            w_vel_x, w_vel_y;

    assign draw_ready_out   = rst_in & (state_q == S_IDLE) & ~(&occ_q) & ~del_valid_in;
    assign del_ready_out    = rst_in & (state_q == S_IDLE);
    assign sqrt_start_out   = sqrt_start_q;
    assign sqrt_operand_out = sqrt_operand_q;
    assign wr_en_out        = wr_en_q;
    assign wr_addr_out      = wr_addr_q;
    assign wr_data_out      = wr_data_q;
    assign occupancy_out    = occ_q;
    assign full_out         = full_q;
    assign busy_out         = busy_q;
    assign err_out          = err_q;

    // Circle geometry is taken straight from the request so the sqrt start
    // can be registered at the accept edge and appear in DECODE.
    always_comb begin
        w_sum_x = {1'b0, draw_props_in[79:70]} + {1'b0, draw_props_in[59:50]};
        w_sum_y = {1'b0, draw_props_in[69:60]} + {1'b0, draw_props_in[49:40]};
        w_cx    = 10'(w_sum_x >> 1);
        w_cy    = 10'(w_sum_y >> 1);
        w_dx    = (draw_props_in[59:50] >= w_cx) ? draw_props_in[59:50] - w_cx
                                                 : w_cx - draw_props_in[59:50];
        w_dy    = (draw_props_in[49:40] >= w_cy) ? draw_props_in[49:40] - w_cy
                                                 : w_cy - draw_props_in[49:40];
        w_sq_x  = {10'd0, w_dx} * {10'd0, w_dx};
        w_sq_y  = {10'd0, w_dy} * {10'd0, w_dy};
    end

    always_comb begin
        w_free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) w_free_slot = SLOT_W'(i);
        end
    end

    always_comb begin
        case (step_q)
            2'd0:    {w_pt_x, w_pt_y} = props_q[79:60];
            2'd1:    {w_pt_x, w_pt_y} = props_q[59:40];
            2'd2:    {w_pt_x, w_pt_y} = props_q[39:20];
            default: {w_pt_x, w_pt_y} = props_q[19:0];
        endcase
    end

    always_comb begin
`ifdef DRAW_COMMIT_VEL_INIT_EN
        w_vel_x = props_q[82] ? 16'd0 : vel_x_q;
        w_vel_y = props_q[82] ? 16'd0 : vel_y_q;
`else
        w_vel_x = 16'd0;
        w_vel_y = 16'd0;
`endif
    end

    always_comb begin
        state_d        = state_q;
        props_d        = props_q;
        slot_d         = slot_q;
        cx_d           = cx_q;
        cy_d           = cy_q;
        min_x_d        = min_x_q;
        max_x_d        = max_x_q;
        min_y_d        = min_y_q;
        max_y_d        = max_y_q;
        step_d         = step_q;
        wait_cnt_d     = wait_cnt_q;
        occ_d          = occ_q;
        err_d          = err_q;
        sqrt_start_d   = 1'b0;
        sqrt_operand_d = sqrt_operand_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
`ifdef DRAW_COMMIT_VEL_INIT_EN
        vel_x_d        = vel_x_q;
        vel_y_d        = vel_y_q;
`endif
        w_enter_write  = 1'b0;
        w_params       = '0;
        w_pos_x        = '0;
        w_pos_y        = '0;

        case (state_q)
            S_IDLE: begin
                if (del_valid_in) begin
                    if ((32'(del_slot_in) >= 32'(NUM_SLOTS)) || !occ_q[del_slot_in])
                        err_d = 1'b1;
                    else
                        occ_d[del_slot_in] = 1'b0;
                end else if (draw_valid_in && !(&occ_q)) begin
                    props_d = draw_props_in;
                    slot_d  = w_free_slot;
                    cx_d    = w_cx;
                    cy_d    = w_cy;
                    state_d = S_DECODE;
`ifdef DRAW_COMMIT_VEL_INIT_EN
                    vel_x_d = init_vel_x_in;
                    vel_y_d = init_vel_y_in;
`endif
                    if (draw_props_in[81:80] == C_ID_CIRCLE) begin
                        sqrt_start_d   = 1'b1;
                        sqrt_operand_d = w_sq_x + w_sq_y;
                    end
                end
            end
            S_DECODE: begin
                case (props_q[81:80])
                    C_ID_LINE: begin
                        w_enter_write = 1'b1;
                        w_params      = {props_q[59:50], props_q[49:40], 16'd0};
                        w_pos_x       = props_q[79:70];
                        w_pos_y       = props_q[69:60];
                    end
                    C_ID_CIRCLE: begin
                        state_d    = S_SQRT_WAIT;
                        wait_cnt_d = '0;
                    end
                    C_ID_RECT: begin
                        state_d = S_MINMAX;
                        step_d  = 2'd0;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_SQRT_WAIT: begin
                if (sqrt_done_in) begin
                    w_enter_write = 1'b1;
                    w_params      = {sqrt_result_in, 26'd0};
                    w_pos_x       = cx_q;
                    w_pos_y       = cy_q;
                end else if (wait_cnt_q == C_CNT_W'(SQRT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + C_CNT_W'(1);
                end
            end
            S_MINMAX: begin
                if (step_q == 2'd0) begin
                    min_x_d = w_pt_x;
                    max_x_d = w_pt_x;
                    min_y_d = w_pt_y;
                    max_y_d = w_pt_y;
                end else begin
                    if (w_pt_x < min_x_q) min_x_d = w_pt_x;
                    if (w_pt_x > max_x_q) max_x_d = w_pt_x;
                    if (w_pt_y < min_y_q) min_y_d = w_pt_y;
                    if (w_pt_y > max_y_q) max_y_d = w_pt_y;
                end
                // Last fold feeds the write record directly from the _d values.
                if (step_q == 2'd3) begin
                    w_enter_write = 1'b1;
                    w_params      = {max_x_d - min_x_d, max_y_d - min_y_d, 16'd0};
                    w_pos_x       = min_x_d;
                    w_pos_y       = min_y_d;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            S_WRITE: begin
                occ_d[slot_q] = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (w_enter_write) begin
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = slot_q;
            wr_data_d = {props_q[82], props_q[81:80], w_params, w_pos_y, w_pos_x,
                         w_vel_x, w_vel_y};
        end

        busy_d = (state_d != S_IDLE);
        full_d = &occ_d;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q        <= S_IDLE;
            props_q        <= '0;
            slot_q         <= '0;
            cx_q           <= '0;
            cy_q           <= '0;
            min_x_q        <= '0;
            max_x_q        <= '0;
            min_y_q        <= '0;
            max_y_q        <= '0;
            step_q         <= '0;
            wait_cnt_q     <= '0;
            occ_q          <= '0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            full_q         <= 1'b0;
            sqrt_start_q   <= 1'b0;
            sqrt_operand_q <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
`ifdef DRAW_COMMIT_VEL_INIT_EN
            vel_x_q        <= '0;
            vel_y_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            props_q        <= props_d;
            slot_q         <= slot_d;
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            min_x_q        <= min_x_d;
            max_x_q        <= max_x_d;
            min_y_q        <= min_y_d;
            max_y_q        <= max_y_d;
            step_q         <= step_d;
            wait_cnt_q     <= wait_cnt_d;
            occ_q          <= occ_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
            full_q         <= full_d;
            sqrt_start_q   <= sqrt_start_d;
            sqrt_operand_q <= sqrt_operand_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
`ifdef DRAW_COMMIT_VEL_INIT_EN
            vel_x_q        <= vel_x_d;
            vel_y_q        <= vel_y_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_commit_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_draw_commit_scheduler
// Brief    : Directed, scoreboard-checked bench for draw_commit_scheduler.
// Revision : 1.0
// ============================================================================
module tb_draw_commit_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        draw_valid_in;
    logic        draw_ready_out;
    logic [82:0] draw_props_in;
    logic        del_valid_in;
    logic [2:0]  del_slot_in;
    logic        del_ready_out;
    logic        sqrt_start_out;
    logic [19:0] sqrt_operand_out;
    logic        sqrt_done_in;
    logic [9:0]  sqrt_result_in;
    logic        wr_en_out;
    logic [2:0]  wr_addr_out;
    logic [90:0] wr_data_out;
    logic [7:0]  occupancy_out;
    logic        full_out;
    logic        busy_out;
    logic        err_out;

    draw_commit_scheduler #(
        .NUM_SLOTS    (8),
        .SLOT_W       (3),
        .SQRT_TIMEOUT (64)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .draw_valid_in    (draw_valid_in),
        .draw_ready_out   (draw_ready_out),
        .draw_props_in    (draw_props_in),
`ifdef DRAW_COMMIT_VEL_INIT_EN
        .init_vel_x_in    (16'h0),
        .init_vel_y_in    (16'h0),
`endif
        .del_valid_in     (del_valid_in),
        .del_slot_in      (del_slot_in),
        .del_ready_out    (del_ready_out),
        .sqrt_start_out   (sqrt_start_out),
        .sqrt_operand_out (sqrt_operand_out),
        .sqrt_done_in     (sqrt_done_in),
        .sqrt_result_in   (sqrt_result_in),
        .wr_en_out        (wr_en_out),
        .wr_addr_out      (wr_addr_out),
        .wr_data_out      (wr_data_out),
        .occupancy_out    (occupancy_out),
        .full_out         (full_out),
        .busy_out         (busy_out),
        .err_out          (err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0]  addr;
        logic [90:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t_acc    = 0;
    int   n_wr     = 0;
    int   n_start  = 0;

    always @(negedge clk_in) begin
        if (wr_en_out === 1'b1)      n_wr    <= n_wr + 1;
        if (sqrt_start_out === 1'b1) n_start <= n_start + 1;
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
        cyc = cyc + 1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [82:0] mk_props(input logic st, input logic [1:0] id,
            input logic [9:0] ax, input logic [9:0] ay, input logic [9:0] bx, input logic [9:0] by,
            input logic [9:0] cx, input logic [9:0] cy, input logic [9:0] ex, input logic [9:0] ey);
        return {st, id, ax, ay, bx, by, cx, cy, ex, ey};
    endfunction

    function automatic logic [90:0] exp_rec(input logic st, input logic [1:0] id,
            input logic [35:0] par, input logic [9:0] px, input logic [9:0] py);
        return {st, id, par, py, px, 32'd0};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, " wr_en"},   wr_en_out, 0);
        check({tag, " wr_addr"}, wr_addr_out, 0);
        check({tag, " wr_data"}, wr_data_out, 0);
        check({tag, " start"},   sqrt_start_out, 0);
        check({tag, " operand"}, sqrt_operand_out, 0);
        check({tag, " occ"},     occupancy_out, 0);
        check({tag, " full"},    full_out, 0);
        check({tag, " busy"},    busy_out, 0);
        check({tag, " err"},     err_out, 0);
    endtask

    task automatic accept(input logic [82:0] props, input logic [2:0] a, input logic [90:0] d,
                          input int lat, input bit expect_wr, input string tag);
        exp_t e;
        draw_props_in = props;
        draw_valid_in = 1'b1;
        #1;
        check({tag, " draw_ready"}, draw_ready_out, 1);
        tick();
        t_acc         = cyc - 1;
        draw_valid_in = 1'b0;
        if (expect_wr) begin
            e.addr = a;
            e.data = d;
            e.lat  = lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_write(input string tag, input int max_cyc);
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (wr_en_out === 1'b1) seen = 1'b1;
            else tick();
        end
        check({tag, " write seen"}, seen, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                check({tag, " latency"}, cyc - t_acc, e.lat);
                check({tag, " addr"}, wr_addr_out, e.addr);
                check({tag, " data"}, wr_data_out, e.data);
                tick();
                check({tag, " wr_en one cycle"}, wr_en_out, 0);
            end
        end
    endtask

    task automatic do_delete(input logic [2:0] s, input string tag);
        del_slot_in  = s;
        del_valid_in = 1'b1;
        #1;
        check({tag, " del_ready"}, del_ready_out, 1);
        tick();
        del_valid_in = 1'b0;
    endtask

    initial begin
        logic [82:0] lp;
        logic [82:0] circ;
        logic [82:0] rect;
        int          n0;

        rst_in         = 1'b0;
        draw_valid_in  = 1'b0;
        draw_props_in  = '0;
        del_valid_in   = 1'b0;
        del_slot_in    = '0;
        sqrt_done_in   = 1'b0;
        sqrt_result_in = '0;
        circ = mk_props(1'b0, 2'b01, 10'd100, 10'd100, 10'd130, 10'd140, 10'd0, 10'd0, 10'd0, 10'd0);
        rect = mk_props(1'b0, 2'b11, 10'd40, 10'd90, 10'd10, 10'd30, 10'd60, 10'd20, 10'd25, 10'd70);

        tick();
        tick();
        check_zero("reset");
        rst_in = 1'b1;
        #1;
        check("idle draw_ready", draw_ready_out, 1);
        check("idle del_ready", del_ready_out, 1);
        tick();

        // Line
        accept(mk_props(1'b1, 2'b10, 10'd100, 10'd50, 10'd200, 10'd80, 10'd0, 10'd0, 10'd0, 10'd0),
               3'd0, exp_rec(1'b1, 2'b10, {10'd200, 10'd80, 16'd0}, 10'd100, 10'd50), 2, 1'b1, "line");
        wait_write("line", 10);
        check("line occ", occupancy_out, 8'h01);
        check("line busy", busy_out, 0);

        // Circle: sqrt result returned five cycles after the start pulse
        n0 = n_start;
        accept(circ, 3'd1, exp_rec(1'b0, 2'b01, {10'd25, 26'd0}, 10'd115, 10'd120), 7, 1'b1, "circle");
        check("circle start", sqrt_start_out, 1);
        check("circle operand", sqrt_operand_out, 20'd625);
        tick();
        check("circle start pulse", sqrt_start_out, 0);
        while (cyc < t_acc + 6) tick();
        sqrt_done_in   = 1'b1;
        sqrt_result_in = 10'd25;
        tick();
        sqrt_done_in   = 1'b0;
        sqrt_result_in = '0;
        wait_write("circle", 10);
        check("circle one start", n_start - n0, 1);
        check("circle occ", occupancy_out, 8'h03);

        // Rectangle
        accept(rect, 3'd2, exp_rec(1'b0, 2'b11, {10'd50, 10'd70, 16'd0}, 10'd10, 10'd20), 6, 1'b1, "rect");
        wait_write("rect", 12);
        check("rect occ", occupancy_out, 8'h07);

        // id=00 is silently dropped
        n0 = n_wr;
        accept(mk_props(1'b0, 2'b00, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8),
               3'd0, '0, 0, 1'b0, "none");
        tick();
        tick();
        check("none busy", busy_out, 0);
        check("none writes", n_wr - n0, 0);
        check("none occ", occupancy_out, 8'h07);
        check("none err", err_out, 0);

        // Sqrt timeout
        n0 = n_wr;
        accept(circ, 3'd0, '0, 0, 1'b0, "timeout");
        while (cyc < t_acc + 65) tick();
        check("timeout err before", err_out, 0);
        check("timeout busy before", busy_out, 1);
        tick();
        check("timeout err", err_out, 1);
        check("timeout busy", busy_out, 0);
        check("timeout occ", occupancy_out, 8'h07);
        check("timeout writes", n_wr - n0, 0);
        sqrt_done_in   = 1'b1;
        sqrt_result_in = 10'd9;
        tick();
        sqrt_done_in   = 1'b0;
        sqrt_result_in = '0;
        tick();
        tick();
        check("late done writes", n_wr - n0, 0);
        check("late done busy", busy_out, 0);
        check("late done occ", occupancy_out, 8'h07);

        // Reset during rectangle MINMAX
        n0 = n_wr;
        accept(rect, 3'd0, '0, 0, 1'b0, "rst");
        tick();
        tick();
        check("rst minmax busy", busy_out, 1);
        rst_in = 1'b0;
        tick();
        check_zero("mid-op reset");
        rst_in = 1'b1;
        repeat (8) tick();
        check("rst no write", n_wr - n0, 0);

        // Fill all eight slots with lines
        for (int i = 0; i < 8; i++) begin
            lp = mk_props(i[0], 2'b10, 10'(10 * i + 1), 10'(20 * i + 2), 10'(300 + i), 10'(400 + i),
                          10'd0, 10'd0, 10'd0, 10'd0);
            accept(lp, 3'(i), exp_rec(i[0], 2'b10, {10'(300 + i), 10'(400 + i), 16'd0},
                   10'(10 * i + 1), 10'(20 * i + 2)), 2, 1'b1, "fill");
            wait_write("fill", 10);
        end
        check("fill occ", occupancy_out, 8'hFF);
        check("fill full", full_out, 1);
        draw_props_in = lp;
        draw_valid_in = 1'b1;
        #1;
        check("full draw_ready", draw_ready_out, 0);
        tick();
        draw_valid_in = 1'b0;
        check("full no accept", busy_out, 0);

        do_delete(3'd3, "del3");
        check("del3 occ", occupancy_out, 8'hF7);
        check("del3 full", full_out, 0);
        check("del3 err", err_out, 0);

        // Delete and draw together: delete wins
        del_slot_in   = 3'd5;
        del_valid_in  = 1'b1;
        draw_props_in = lp;
        draw_valid_in = 1'b1;
        #1;
        check("collide draw_ready", draw_ready_out, 0);
        check("collide del_ready", del_ready_out, 1);
        tick();
        del_valid_in  = 1'b0;
        draw_valid_in = 1'b0;
        check("collide occ", occupancy_out, 8'hD7);
        check("collide busy", busy_out, 0);

        lp = mk_props(1'b0, 2'b10, 10'd7, 10'd8, 10'd9, 10'd10, 10'd0, 10'd0, 10'd0, 10'd0);
        accept(lp, 3'd3, exp_rec(1'b0, 2'b10, {10'd9, 10'd10, 16'd0}, 10'd7, 10'd8), 2, 1'b1, "refill");
        wait_write("refill", 10);
        check("refill occ", occupancy_out, 8'hDF);

        do_delete(3'd5, "del empty");
        check("del empty err", err_out, 1);
        check("del empty occ", occupancy_out, 8'hDF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/draw_commit_scheduler.md
Name: draw_commit_scheduler

Overview:
- Sequences the conversion of drawn shapes into physics-storage records.
- Accepts one draw request at a time and allocates a free object slot.
- Drives a shared external sqrt unit for circles and computes rectangle bounds over four sequential compare cycles.
- Issues a single storage write per object and services slot delete requests.
- Sits between the camera/draw front end and the object storage BRAM.

Parameters:
- NUM_SLOTS, 8, number of object storage slots.
- SLOT_W, 3, slot address width; equals $clog2(NUM_SLOTS).
- SQRT_TIMEOUT, 64, maximum SQRT_WAIT cycles before the object is dropped.

Ports:
- clk_in  input  1  system clock; all logic is on the rising edge.
- rst_in  input  1  synchronous reset, active-low (asserted when 0).
- draw_valid_in  input  1  draw request valid.
- draw_ready_out  output  1  draw request accepted when high with draw_valid_in.
- draw_props_in  input  83  [82] is_static, [81:80] id, then four 10-bit (x,y) points: p1x[79:70], p1y[69:60], p2x[59:50], p2y[49:40], p3x[39:30], p3y[29:20], p4x[19:10], p4y[9:0].
- del_valid_in  input  1  delete request.
- del_slot_in  input  SLOT_W  slot to free.
- del_ready_out  output  1  delete accepted.
- sqrt_start_out  output  1  one-cycle start pulse to the sqrt unit.
- sqrt_operand_out  output  20  radius squared.
- sqrt_done_in  input  1  sqrt result valid; a one-cycle pulse.
- sqrt_result_in  input  10  integer square root.
- wr_en_out  output  1  storage write strobe.
- wr_addr_out  output  SLOT_W  slot address.
- wr_data_out  output  91  {is_static, id[1:0], params[35:0], pos_y[9:0], pos_x[9:0], vel_x[15:0], vel_y[15:0]}.
- occupancy_out  output  NUM_SLOTS  one bit per used slot.
- full_out  output  1  all slots used.
- busy_out  output  1  FSM is not in IDLE.
- err_out  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - state goes to IDLE.
  - All outputs are 0, occupancy is 0 and err is 0.
  - A reset mid-operation abandons the object; no write occurs.
  - sqrt_done_in is ignored in every state except SQRT_WAIT.
- IDLE state:
  - draw_ready_out = !full & !del_valid_in. Delete has priority over draw.
  - del_ready_out = 1.
- Delete handling:
  - On del_valid_in in IDLE, the occupancy bit is cleared at the next edge; state stays IDLE.
  - Freeing an empty slot, or del_slot_in >= NUM_SLOTS, is a no-op and sets err.
- Accept:
  - On draw_valid&draw_ready in cycle T, latch draw_props and the lowest-index free slot, then go to DECODE.
  - id=00 returns to IDLE from DECODE with no write, no slot consumed and no error.
- Line (id=10):
  - pos = p1; params = {p2x, p2y, 16'b0}.
  - DECODE(T+1) -> WRITE(T+2).
- Circle (id=01):
  - Centre: cx = (p1x+p2x)>>1 and cy = (p1y+p2y)>>1, using 11-bit sums.
  - dx = |p2x-cx|, dy = |p2y-cy|; operand = dx*dx + dy*dy, 20 bits, which cannot overflow.
  - In DECODE (T+1), sqrt_start_out pulses high with sqrt_operand_out valid.
  - SQRT_WAIT begins at T+2 and counts cycles.
  - On sqrt_done_in, latch sqrt_result_in and go to WRITE the next cycle.
  - params = {radius, 26'b0}; pos = (cx, cy).
  - If the counter reaches SQRT_TIMEOUT: set err, go to IDLE, no write, slot stays free.
- Rectangle (id=11):
  - MINMAX runs T+2..T+5, folding one point per cycle (p1..p4) into min/max x and y.
  - pos = (min_x, min_y); params = {max_x-min_x, max_y-min_y, 16'b0}.
  - WRITE at T+6.
- WRITE state:
  - wr_en_out is high for exactly one cycle, with wr_addr_out = allocated slot.
  - The occupancy bit is set at the end of WRITE; then go to IDLE.
  - vel_x = vel_y = 0.
- full_out = &occupancy_out. busy_out = (state != IDLE).
- Outputs are registered except draw_ready_out and del_ready_out.

Optional Feature:
- Macro: DRAW_COMMIT_VEL_INIT_EN.
- When defined:
  - Adds input ports init_vel_x_in[15:0] and init_vel_y_in[15:0].
  - Both are latched at accept and written into the vel fields.
  - is_static=1 forces both vel fields to 0.
- When undefined: the ports are absent and the vel fields are always 0.

Test Plan:
- Line:
  - Stimulus: id=10, static=1, p1=(100,50), p2=(200,80), accepted at T.
  - Response: wr_en at T+2, addr 0, pos_x=100, pos_y=50, params={200,80,0}, occupancy=8'h01.
- Circle:
  - Stimulus: p1=(100,100), p2=(130,140); sqrt model returns 25 five cycles after start.
  - Response: operand=625, pos=(115,120), params[35:26]=25, exactly one sqrt_start pulse.
- Rectangle:
  - Stimulus: points (40,90), (10,30), (60,20), (25,70).
  - Response: wr_en at T+6, pos=(10,20), params={50,70,0}.
- Full and delete:
  - Stimulus: write 8 lines; delete slot 3; draw once more.
  - Response: after the 8 lines, full_out=1 and draw_ready_out=0. After the delete, occupancy=8'hF7. The next draw writes addr 3.
- Timeout:
  - Stimulus: circle with sqrt_done_in held low.
  - Response: err=1 after 64 wait cycles, no wr_en, occupancy unchanged, state IDLE. A later sqrt_done pulse is ignored.
- Reset and collisions:
  - Stimulus: drop rst_in low during rectangle MINMAX.
  - Response: no write; all outputs 0 on the next cycle.
  - Stimulus: del_valid and draw_valid asserted together in IDLE.
  - Response: the delete is taken first; draw_ready_out=0 that cycle.
